parking_gate_sequencer: RTL and testbench

Sequences gate traffic into the 4-spot parking occupancy FSM. Arbitrates between the entry gate and the exit gate, pre-checks each request against current occupancy, and issues exactly one single-cycle command on the FSM's 4-bit `in` bus. It then waits for the FSM's door pulse, holds the door open for a programmable time, and reports ack or reject to the requesting gate.

---
 rtl/parking_pkg.sv | 27 ++
 rtl/parking_gate_sequencer_if.sv | 29 ++
 rtl/parking_door_timer.sv | 36 +++
 rtl/parking_gate_sequencer.sv | 172 +++++++++++++++++
 tb/tb_parking_gate_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate sequencer.
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DOOR  = 3'd3,
        ST_CLEAR = 3'd4
    } seq_state_t;

    localparam logic [3:0] CMD_NONE      = 4'b0000;
    localparam logic [3:0] CMD_ENTER     = 4'b1000;
    localparam logic [1:0] CMD_EXIT_BASE = 2'b01;
    localparam logic [3:0] FULL          = 4'b1111;

    // Number of set bits in a 4-bit occupancy word.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/parking_gate_sequencer_if.sv
// Gate handshake and parking-FSM command bus.
// master: gates plus the parking FSM; slave: the sequencer.
interface parking_gate_sequencer_if;

    logic       enter_req;
    logic       exit_req;
    logic [1:0] exit_place;
    logic [3:0] fsm_state;
    logic       door_open_pulse;

    logic [3:0] fsm_in;
    logic       enter_ack;
    logic       exit_ack;
    logic       reject;
    logic       door_open;
    logic       busy;
    logic [2:0] free_count;

    modport master (
        output enter_req, exit_req, exit_place, fsm_state, door_open_pulse,
        input  fsm_in, enter_ack, exit_ack, reject, door_open, busy, free_count
    );

    modport slave (
        input  enter_req, exit_req, exit_place, fsm_state, door_open_pulse,
        output fsm_in, enter_ack, exit_ack, reject, door_open, busy, free_count
    );

endinterface

// File: rtl/parking_door_timer.sv
// Door hold timer: start loads DOOR_CYCLES-1, done marks the last open cycle.
module parking_door_timer #(
    parameter int DOOR_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int               CW   = $clog2(DOOR_CYCLES + 1);
    localparam logic [CW-1:0]    LOAD = CW'(DOOR_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          active;

    // Down-counter; stops itself after reaching terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            cnt    <= LOAD;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign done = active && (cnt == '0);

endmodule

// File: rtl/parking_gate_sequencer.sv
// Arbitrates entry/exit gates into the 4-spot parking FSM and runs the door.
//
// state | meaning
// IDLE  | arbitrate and pre-check requests
// ISSUE | drive the latched command on fsm_in for one cycle
// WAIT  | wait for door_open_pulse, bounded by WAIT_CYCLES
// DOOR  | hold door_open for DOOR_CYCLES, ack in the first cycle
// CLEAR | one quiet cycle, requests ignored
module parking_gate_sequencer
    import parking_pkg::*;
#(
    parameter int DOOR_CYCLES = 8,
    parameter int WAIT_CYCLES = 2
) (
    input logic                     clk,
    input logic                     rst,
    parking_gate_sequencer_if.slave bus
);

    localparam int            WW        = $clog2(WAIT_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_CYCLES - 1);

    seq_state_t state_q, state_d;
    logic       ptr_exit_q, ptr_exit_d;
    logic       is_enter_q, is_enter_d;
    logic [1:0] place_q, place_d;
    logic [WW-1:0] wait_cnt_q;

    logic grant_valid;
    logic grant_enter;
    logic pre_reject;
    logic timeout;
    logic door_start;
    logic door_done;

    logic [3:0] fsm_in_q, fsm_in_d;
    logic       enter_ack_q, enter_ack_d;
    logic       exit_ack_q, exit_ack_d;
    logic       reject_q, reject_d;
    logic       door_open_q, door_open_d;
    logic       busy_q, busy_d;
    logic [2:0] free_count_q;

    assign door_start = (state_q == ST_WAIT) && bus.door_open_pulse;

    parking_door_timer #(
        .DOOR_CYCLES(DOOR_CYCLES)
    ) u_door_timer (
        .clk  (clk),
        .rst  (rst),
        .start(door_start),
        .done (door_done)
    );

    // State register plus the command context latched at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_exit_q <= 1'b1;
            is_enter_q <= 1'b0;
            place_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            ptr_exit_q <= ptr_exit_d;
            is_enter_q <= is_enter_d;
            place_q    <= place_d;
        end
    end

    // Next state: round-robin grant, occupancy pre-check, wait/door sequencing.
    always_comb begin
        state_d     = state_q;
        ptr_exit_d  = ptr_exit_q;
        is_enter_d  = is_enter_q;
        place_d     = place_q;
        grant_valid = 1'b0;
        grant_enter = 1'b0;
        pre_reject  = 1'b0;
        timeout     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enter_req && bus.exit_req) begin
                    grant_valid = 1'b1;
                    grant_enter = !ptr_exit_q;
                    ptr_exit_d  = !ptr_exit_q;
                end else if (bus.enter_req) begin
                    grant_valid = 1'b1;
                    grant_enter = 1'b1;
                end else if (bus.exit_req) begin
                    grant_valid = 1'b1;
                end
                if (grant_valid) begin
                    pre_reject = grant_enter ? (bus.fsm_state == FULL)
                                             : !bus.fsm_state[bus.exit_place];
                    is_enter_d = grant_enter;
                    place_d    = bus.exit_place;
                    state_d    = pre_reject ? ST_CLEAR : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.door_open_pulse) begin
                    state_d = ST_DOOR;
                end else if (wait_cnt_q == '0) begin
                    timeout = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_DOOR: begin
                if (door_done) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode: next-cycle values, registered below so every output is a flop.
    always_comb begin
        fsm_in_d = CMD_NONE;
        if (state_d == ST_ISSUE) begin
            fsm_in_d = is_enter_d ? CMD_ENTER : {CMD_EXIT_BASE, place_d};
        end
        enter_ack_d = door_start && is_enter_q;
        exit_ack_d  = door_start && !is_enter_q;
        reject_d    = pre_reject || timeout;
        door_open_d = (state_d == ST_DOOR);
        busy_d      = (state_d != ST_IDLE);
    end

    // Output registers and the lagging free-spot count.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_in_q     <= CMD_NONE;
            enter_ack_q  <= 1'b0;
            exit_ack_q   <= 1'b0;
            reject_q     <= 1'b0;
            door_open_q  <= 1'b0;
            busy_q       <= 1'b0;
            free_count_q <= 3'd0;
        end else begin
            fsm_in_q     <= fsm_in_d;
            enter_ack_q  <= enter_ack_d;
            exit_ack_q   <= exit_ack_d;
            reject_q     <= reject_d;
            door_open_q  <= door_open_d;
            busy_q       <= busy_d;
            free_count_q <= popcount4(~bus.fsm_state);
        end
    end

    // Door-pulse timeout: loaded on entry to WAIT, counts down while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            wait_cnt_q <= WAIT_LOAD;
        end else if (state_q == ST_WAIT && wait_cnt_q != '0) begin
            wait_cnt_q <= wait_cnt_q - WW'(1);
        end
    end

    assign bus.fsm_in     = fsm_in_q;
    assign bus.enter_ack  = enter_ack_q;
    assign bus.exit_ack   = exit_ack_q;
    assign bus.reject     = reject_q;
    assign bus.door_open  = door_open_q;
    assign bus.busy       = busy_q;
    assign bus.free_count = free_count_q;

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Scoreboard bench: stimulus queues expected events and levels by cycle,
// a negedge monitor pops and compares them.
module tb_parking_gate_sequencer;

    localparam int D = 8;
    localparam int W = 2;
    localparam int P = D + 4;

    localparam int K_CMD   = 0;
    localparam int K_EACK  = 1;
    localparam int K_XACK  = 2;
    localparam int K_REJ   = 3;
    localparam int K_DOOR  = 4;
    localparam int S_FIN   = 10;
    localparam int S_BUSY  = 11;
    localparam int S_DOOR  = 12;
    localparam int S_FREE  = 13;
    localparam int S_PULSE = 14;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   door_len = 0;
    logic finish_req;

    exp_t ev_q[$];
    exp_t st_q[$];

    logic [3:0] occ = 4'b0000;
    logic       pulse = 1'b0;
    logic       model_en;
    logic       load_en;
    logic [3:0] load_val;

    parking_gate_sequencer_if bus();

    parking_gate_sequencer #(
        .DOOR_CYCLES(D),
        .WAIT_CYCLES(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Parking occupancy FSM model: enter takes the lowest free spot, exit frees a spot.
    assign bus.fsm_state       = occ;
    assign bus.door_open_pulse = pulse;

    function automatic logic [3:0] take_lowest(input logic [3:0] v);
        logic [3:0] r;
        logic       found;
        r = v;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && !v[i]) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        pulse <= 1'b0;
        if (load_en) begin
            occ <= load_val;
        end else if (model_en) begin
            if (bus.fsm_in == 4'b1000 && occ != 4'b1111) begin
                occ   <= take_lowest(occ);
                pulse <= 1'b1;
            end else if (bus.fsm_in[3:2] == 2'b01 && occ[bus.fsm_in[1:0]]) begin
                occ[bus.fsm_in[1:0]] <= 1'b0;
                pulse <= 1'b1;
            end
        end
    end

    function automatic string kname(input int k);
        case (k)
            K_CMD:   return "fsm_in_cmd";
            K_EACK:  return "enter_ack";
            K_XACK:  return "exit_ack";
            K_REJ:   return "reject";
            K_DOOR:  return "door_open_len";
            S_FIN:   return "fsm_in_level";
            S_BUSY:  return "busy";
            S_DOOR:  return "door_open";
            S_FREE:  return "free_count";
            S_PULSE: return "pulses";
            default: return "unknown";
        endcase
    endfunction

    function automatic int status_val(input int k);
        case (k)
            S_FIN:   return int'(bus.fsm_in);
            S_BUSY:  return int'(bus.busy);
            S_DOOR:  return int'(bus.door_open);
            S_FREE:  return int'(bus.free_count);
            S_PULSE: return int'({bus.enter_ack, bus.exit_ack, bus.reject});
            default: return -1;
        endcase
    endfunction

    task automatic take(input int kind, input int val);
        exp_t e;
        checks++;
        if (ev_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got %0d at cycle %0d, required no event",
                     kname(kind), val, cyc);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                         kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    // Monitor: output events and scheduled level checks, then the summary.
    always @(negedge clk) begin
        exp_t s;
        int   act;
        if (bus.fsm_in != 4'd0) take(K_CMD, int'(bus.fsm_in));
        if (bus.enter_ack)      take(K_EACK, 1);
        if (bus.exit_ack)       take(K_XACK, 1);
        if (bus.reject)         take(K_REJ, 1);
        if (bus.door_open === 1'b1) begin
            door_len = door_len + 1;
        end else if (door_len != 0) begin
            take(K_DOOR, door_len);
            door_len = 0;
        end
        while (st_q.size() != 0 && st_q[0].cyc <= cyc) begin
            s = st_q.pop_front();
            act = status_val(s.kind);
            checks++;
            if (s.cyc != cyc || act != s.val) begin
                errors++;
                $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d",
                         kname(s.kind), act, cyc, s.val, s.cyc);
            end
        end
        if (finish_req) begin
            checks++;
            if (ev_q.size() != 0) begin
                errors++;
                $display("FAIL pending_events: got %0d left, required 0 (next %s at cycle %0d)",
                         ev_q.size(), kname(ev_q[0].kind), ev_q[0].cyc);
            end
            checks++;
            if (st_q.size() != 0) begin
                errors++;
                $display("FAIL pending_levels: got %0d left, required 0", st_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic ev(input int kind, input int val, input int c);
        ev_q.push_back('{kind, val, c});
    endtask

    task automatic st(input int kind, input int val, input int c);
        st_q.push_back('{kind, val, c});
    endtask

    task automatic set_occ(input logic [3:0] v);
        load_val = v;
        load_en  = 1'b1;
        tick();
        load_en  = 1'b0;
    endtask

    // Directed scenarios; cycle c is the IDLE cycle in which the request is first seen.
    initial begin
        int c;
        int c1;
        rst            = 1'b1;
        finish_req     = 1'b0;
        model_en       = 1'b1;
        load_en        = 1'b0;
        load_val       = 4'd0;
        bus.enter_req  = 1'b0;
        bus.exit_req   = 1'b0;
        bus.exit_place = 2'd0;

        // Reset values, then free_count follows occupancy one cycle late.
        st(S_FIN, 0, 2);
        st(S_BUSY, 0, 2);
        st(S_DOOR, 0, 2);
        st(S_FREE, 0, 2);
        st(S_PULSE, 0, 2);
        st(S_FREE, 0, 3);
        st(S_FREE, 4, 4);
        wait_until(3);
        rst = 1'b0;

        // Enter on an empty lot.
        wait_until(5);
        c = cyc;
        bus.enter_req = 1'b1;
        ev(K_CMD, 8, c + 1);
        ev(K_EACK, 1, c + 3);
        ev(K_DOOR, D, c + 3 + D);
        st(S_BUSY, 1, c + 1);
        st(S_FREE, 3, c + 3);
        st(S_DOOR, 1, c + 3);
        st(S_BUSY, 1, c + 3 + D);
        st(S_DOOR, 0, c + 3 + D);
        st(S_BUSY, 0, c + 4 + D);
        tick();
        bus.enter_req = 1'b0;
        wait_until(c + 5 + D);

        // Enter on a full lot: immediate reject, no command, no door.
        set_occ(4'b1111);
        c = cyc;
        bus.enter_req = 1'b1;
        ev(K_REJ, 1, c + 1);
        st(S_BUSY, 1, c + 1);
        st(S_FREE, 0, c + 1);
        st(S_BUSY, 0, c + 2);
        tick();
        bus.enter_req = 1'b0;
        wait_until(c + 4);

        // Exit from an occupied spot 2.
        set_occ(4'b0101);
        c = cyc;
        bus.exit_req   = 1'b1;
        bus.exit_place = 2'd2;
        ev(K_CMD, 6, c + 1);
        ev(K_XACK, 1, c + 3);
        ev(K_DOOR, D, c + 3 + D);
        st(S_FREE, 2, c + 1);
        st(S_FREE, 3, c + 3);
        tick();
        bus.exit_req   = 1'b0;
        bus.exit_place = 2'd0;
        wait_until(c + 5 + D);

        // Exit from an empty spot 1: reject.
        set_occ(4'b0101);
        c = cyc;
        bus.exit_req   = 1'b1;
        bus.exit_place = 2'd1;
        ev(K_REJ, 1, c + 1);
        st(S_FIN, 0, c + 1);
        tick();
        bus.exit_req = 1'b0;
        wait_until(c + 3);

        // Both requests held from reset: exit, enter, exit.
        set_occ(4'b0011);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c = cyc;
        bus.enter_req  = 1'b1;
        bus.exit_req   = 1'b1;
        bus.exit_place = 2'd0;
        ev(K_CMD, 4, c + 1);
        ev(K_XACK, 1, c + 3);
        ev(K_DOOR, D, c + 3 + D);
        ev(K_CMD, 8, c + P + 1);
        ev(K_EACK, 1, c + P + 3);
        ev(K_DOOR, D, c + P + 3 + D);
        ev(K_CMD, 4, c + 2*P + 1);
        ev(K_XACK, 1, c + 2*P + 3);
        ev(K_DOOR, D, c + 2*P + 3 + D);
        wait_until(c + 2*P + 1);
        bus.enter_req = 1'b0;
        bus.exit_req  = 1'b0;
        wait_until(c + 3*P + 1);

        // No door pulse: WAIT times out.
        model_en = 1'b0;
        set_occ(4'b0000);
        c = cyc;
        bus.enter_req = 1'b1;
        ev(K_CMD, 8, c + 1);
        ev(K_REJ, 1, c + W + 2);
        st(S_DOOR, 0, c + 3);
        st(S_BUSY, 1, c + W + 2);
        st(S_BUSY, 0, c + W + 3);
        tick();
        bus.enter_req = 1'b0;
        wait_until(c + W + 4);
        model_en = 1'b1;

        // Reset in the third door cycle, then both requests: exit wins again.
        c = cyc;
        bus.enter_req = 1'b1;
        ev(K_CMD, 8, c + 1);
        ev(K_EACK, 1, c + 3);
        ev(K_DOOR, 3, c + 6);
        st(S_DOOR, 1, c + 5);
        st(S_DOOR, 0, c + 6);
        st(S_BUSY, 0, c + 6);
        st(S_FIN, 0, c + 6);
        tick();
        bus.enter_req = 1'b0;
        wait_until(c + 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c1 = cyc;
        bus.enter_req  = 1'b1;
        bus.exit_req   = 1'b1;
        bus.exit_place = 2'd0;
        ev(K_CMD, 4, c1 + 1);
        ev(K_XACK, 1, c1 + 3);
        ev(K_DOOR, D, c1 + 3 + D);
        tick();
        bus.enter_req = 1'b0;
        bus.exit_req  = 1'b0;
        wait_until(c1 + 6 + D);

        finish_req = 1'b1;
    end

endmodule
